// File: rtl/sifh_frame_scheduler.sv
// sifh_frame_scheduler
//   Frame-level sequencer for one SiFH histogram SRAM. Each frame runs
//   CLEAR -> ACQ -> DRAIN -> PEAK -> DONE. The block owns the single SRAM
//   read/write port pair and grants it by phase:
//     CLEAR       internal clear engine (zero-fill 0..RAM_DEPTH-1)
//     ACQ, DRAIN  histogram accumulator (h_*)
//     PEAK        peak detector (pd_*)
//   Requests from a non-granted requester are dropped and raise port_err.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   start, continuous, abort        frame control
//   hist_en                         accumulator may count (ACQ only)
//   h_rEnable/h_raddr/h_wEnable/h_waddr/h_wdata        accumulator port
//   pd_start, pd_finish                                peak-detector handshake
//   pd_rEnable/pd_raddr/pd_wEnable/pd_waddr/pd_wdata   peak-detector port
//   rEnable/raddr/wEnable/waddr/wdata                  SRAM port
//   busy, frame_done, pd_timeout, port_err, state_o    status
module sifh_frame_scheduler #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RAM_DEPTH = 512,
  parameter int unsigned ACQ_LEN   = 4096,
  parameter int unsigned DRAIN_LEN = 2,
  parameter int unsigned PD_TMO    = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  output logic              hist_en,
  input  logic              h_rEnable,
  input  logic [ADDR_W-1:0] h_raddr,
  input  logic              h_wEnable,
  input  logic [ADDR_W-1:0] h_waddr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              pd_start,
  input  logic              pd_finish,
  input  logic              pd_rEnable,
  input  logic [ADDR_W-1:0] pd_raddr,
  input  logic              pd_wEnable,
  input  logic [ADDR_W-1:0] pd_waddr,
  input  logic [DATA_W-1:0] pd_wdata,
  output logic              rEnable,
  output logic [ADDR_W-1:0] raddr,
  output logic              wEnable,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              pd_timeout,
  output logic              port_err,
  output logic [2:0]        state_o
);

  // One shared phase counter, wide enough for the longest phase.
  localparam int unsigned MAX_A = (RAM_DEPTH > ACQ_LEN) ? RAM_DEPTH : ACQ_LEN;
  localparam int unsigned MAX_B = (DRAIN_LEN > PD_TMO) ? DRAIN_LEN : PD_TMO;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] CLR_LAST = CW'(RAM_DEPTH - 1);
  localparam logic [CW-1:0] ACQ_LAST = CW'(ACQ_LEN - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'(DRAIN_LEN - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(PD_TMO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACQ   = 3'd2,
    DRAIN = 3'd3,
    PEAK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          hist_en_q;
  logic          pd_start_q;
  logic          frame_done_q;
  logic          busy_q;
  logic          pd_timeout_q;
  logic          port_err_q;

  logic grant_h;
  logic grant_pd;
  logic err_now;

  assign grant_h  = (state_q == ACQ) || (state_q == DRAIN);
  assign grant_pd = (state_q == PEAK);
  assign err_now  = ((h_rEnable  || h_wEnable)  && !grant_h) ||
                    ((pd_rEnable || pd_wEnable) && !grant_pd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hist_en_q    <= 1'b0;
      pd_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      pd_timeout_q <= 1'b0;
      port_err_q   <= 1'b0;
    end else begin
      pd_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        hist_en_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q      <= CLEAR;
              cnt_q        <= '0;
              busy_q       <= 1'b1;
              pd_timeout_q <= 1'b0;
              port_err_q   <= 1'b0;
            end
          end
          CLEAR: begin
            if (cnt_q == CLR_LAST) begin
              state_q   <= ACQ;
              cnt_q     <= '0;
              hist_en_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ACQ: begin
            if (cnt_q == ACQ_LAST) begin
              state_q   <= DRAIN;
              cnt_q     <= '0;
              hist_en_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DRAIN: begin
            if (cnt_q == DRN_LAST) begin
              state_q    <= PEAK;
              cnt_q      <= '0;
              pd_start_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          PEAK: begin
            // A finish on the last watchdog cycle wins over the timeout.
            if (pd_finish) begin
              state_q      <= DONE;
              cnt_q        <= '0;
              frame_done_q <= 1'b1;
            end else if (cnt_q == TMO_LAST) begin
              state_q      <= DONE;
              cnt_q        <= '0;
              frame_done_q <= 1'b1;
              pd_timeout_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DONE: begin
            cnt_q <= '0;
            if (continuous) begin
              state_q <= CLEAR;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
      // Placed last so a stray request in the start cycle still sticks.
      if (err_now) port_err_q <= 1'b1;
    end
  end

  // SRAM mux: zero-latency, gated by abort in the cycle it is seen.
  always_comb begin
    rEnable = 1'b0;
    raddr   = '0;
    wEnable = 1'b0;
    waddr   = '0;
    wdata   = '0;
    if (!abort) begin
      case (state_q)
        CLEAR: begin
          wEnable = 1'b1;
          waddr   = ADDR_W'(cnt_q);
        end
        ACQ, DRAIN: begin
          rEnable = h_rEnable;
          raddr   = h_raddr;
          wEnable = h_wEnable;
          waddr   = h_waddr;
          wdata   = h_wdata;
        end
        PEAK: begin
          rEnable = pd_rEnable;
          raddr   = pd_raddr;
          wEnable = pd_wEnable;
          waddr   = pd_waddr;
          wdata   = pd_wdata;
        end
        default: ;
      endcase
    end
  end

  assign hist_en    = hist_en_q;
  assign pd_start   = pd_start_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign pd_timeout = pd_timeout_q;
  assign port_err   = port_err_q;
  assign state_o    = state_q;

endmodule
